// File: rtl/fp_pkg.sv
// IEEE-754 single-precision field constants and the special-case classifier shared by the
// multiplier issue controller.
package fp_pkg;

  localparam int unsigned SIGN_BIT = 31;
  localparam int unsigned EXP_MSB  = 30;
  localparam int unsigned EXP_LSB  = 23;
  localparam int unsigned MAN_W    = 23;

  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [7:0]  EXP_ALL1 = 8'hFF;

  typedef enum logic [1:0] {NONE, NAN, INF, ZERO} spec_t;

  typedef struct packed {
    spec_t kind;
    logic  sign;
  } class_t;

  // NaN dominates, then inf, then zero; denormal operands count as zero (flush to zero).
  function automatic class_t classify(input logic [31:0] a, input logic [31:0] b);
    class_t c;
    logic   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    a_nan  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[MAN_W-1:0] != '0);
    b_nan  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[MAN_W-1:0] != '0);
    a_inf  = (a[EXP_MSB:EXP_LSB] == EXP_ALL1) && (a[MAN_W-1:0] == '0);
    b_inf  = (b[EXP_MSB:EXP_LSB] == EXP_ALL1) && (b[MAN_W-1:0] == '0);
    a_zero = (a[EXP_MSB:EXP_LSB] == '0);
    b_zero = (b[EXP_MSB:EXP_LSB] == '0);
    c.sign = a[SIGN_BIT] ^ b[SIGN_BIT];
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      c.kind = NAN;
    end else if (a_inf || b_inf) begin
      c.kind = INF;
    end else if (a_zero || b_zero) begin
      c.kind = ZERO;
    end else begin
      c.kind = NONE;
    end
    return c;
  endfunction

  // Returns {is_nan, is_inf, is_zero}.
  function automatic logic [2:0] flags_of(input logic [31:0] v);
    logic exp_ones, man_zero;
    exp_ones = (v[EXP_MSB:EXP_LSB] == EXP_ALL1);
    man_zero = (v[MAN_W-1:0] == '0);
    return {exp_ones && !man_zero, exp_ones && man_zero, (v[EXP_MSB:0] == '0)};
  endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// Result FIFO with first-word fall-through; pointers wrap modulo DEPTH so any DEPTH >= 2 works.
module fp_result_fifo #(
  parameter int unsigned W     = 39,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fp_mult_issue_ctrl.sv
// Issue/retire controller around a fixed-latency, non-stallable fp multiplier: credit-gated
// issue, a valid/tag pipe matched to the multiplier latency, special-case override, result FIFO.
module fp_mult_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MULT_LAT   = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_a,
  input  logic [WIDTH-1:0]            in_b,
  input  logic [TAG_W-1:0]            in_tag,
  output logic [WIDTH-1:0]            mul_a,
  output logic [WIDTH-1:0]            mul_b,
  input  logic [WIDTH-1:0]            mul_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [TAG_W-1:0]            out_tag,
  output logic [2:0]                  out_flags,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int unsigned OccW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = WIDTH + TAG_W + 3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    class_t           cls;
  } pipe_t;

  pipe_t           pipe_q [MULT_LAT];
  logic [OccW-1:0] occ_q;
  logic            accept, pop, push, empty;
  logic [WIDTH-1:0] push_val;
  logic [2:0]      push_flags;
  logic [EntW-1:0] head;

  // occ_q counts in-flight plus queued results, so every issued op already owns a FIFO slot.
  assign in_ready  = !rst && (occ_q < OccW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = pipe_q[MULT_LAT-1].valid;
  assign occupancy = occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      occ_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) pipe_q[i] <= '0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
      end
      pipe_q[0] <= '0;
      if (accept) pipe_q[0] <= pipe_t'{1'b1, in_tag, classify(in_a, in_b)};
      for (int i = 1; i < MULT_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      if (accept && !pop) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop && !accept) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  always_comb begin
    push_val = mul_out;
    unique case (pipe_q[MULT_LAT-1].cls.kind)
      NAN:     push_val = QNAN;
      INF:     push_val = {pipe_q[MULT_LAT-1].cls.sign, EXP_ALL1, {MAN_W{1'b0}}};
      ZERO:    push_val = {pipe_q[MULT_LAT-1].cls.sign, {(WIDTH-1){1'b0}}};
      default: push_val = mul_out;
    endcase
    push_flags = flags_of(push_val);
  end

  fp_result_fifo #(
    .W     (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({push_val, pipe_q[MULT_LAT-1].tag, push_flags}),
    .pop       (pop),
    .head      (head),
    .empty     (empty)
  );

  assign {out_data, out_tag, out_flags} = head;

endmodule

// File: doc/fp_mult_issue_ctrl.md
Name: fp_mult_issue_ctrl

Overview:
- Issue/retire controller wrapped around the pipelined fp_multiplier. It sits directly upstream and downstream of the multiplier datapath.
- Accepts operand pairs over a valid/ready handshake and drives the multiplier's a/b inputs.
- Tracks in-flight operations with a valid/tag shift register matched to the multiplier latency, and overrides IEEE special cases.
- Captures results into a result FIFO with downstream backpressure. The multiplier itself cannot stall, so credit-based issue is required.

Parameters:
- WIDTH, 32, float width (IEEE-754 single only).
- MULT_LAT, 3, clock edges from mul_a/mul_b change to the corresponding mul_out being sampled.
- FIFO_DEPTH, 4, result FIFO entries; must be >= 2.
- TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  user tag.
- mul_a  out  WIDTH  registered operand A to fp_multiplier.
- mul_b  out  WIDTH  registered operand B to fp_multiplier.
- mul_out  in  WIDTH  fp_multiplier result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  3  {is_nan, is_inf, is_zero} of out_data.
- occupancy  out  $clog2(FIFO_DEPTH)+1  in-flight count plus FIFO count.

Behaviour:
- Reset (async):
  - mul_a, mul_b, the shift register, the FIFO pointers/count and the in-flight count all go to 0.
  - out_valid=0, in_ready=0 while rst is high.
  - Any operations in flight at reset assertion are discarded. Reset mid-operation never produces a late push.
- Credits:
  - credits = FIFO_DEPTH - occupancy, computed from registered state only.
  - in_ready = !rst && credits>0.
  - There is no combinational path from out_ready to in_ready. A pop frees its credit from the next cycle.
- Accept:
  - Occurs on an edge where in_valid && in_ready.
  - mul_a<=in_a and mul_b<=in_b.
  - Shift-register stage 0 loads {1, in_tag, special}.
  - Without an accept, mul_a/mul_b hold their values and stage 0 loads valid=0.
- Latency:
  - An operation accepted at edge k pushes to the FIFO at edge k+MULT_LAT, sampling mul_out at that edge.
  - out_valid rises after edge k+MULT_LAT. Minimum in_valid to out_valid is MULT_LAT+1 cycles.
  - The shift register has MULT_LAT stages and shifts every cycle unconditionally.
- Special-case override (classified at accept, carried in the pipe; all replace mul_out at push):
  - Either operand NaN (exp=FF, man!=0), or zero*inf → 0x7FC00000.
  - Either operand inf (otherwise) → {sa^sb, FF, 0}.
  - Either operand zero or denormal (exp=00) → {sa^sb, 00, 0}; denormals are flushed to zero.
  - Otherwise → mul_out.
  - out_flags are recomputed from the pushed value.
- FIFO:
  - First-word fall-through; pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same edge are both performed and the count is unchanged.
  - Push when full is impossible by construction; the bench asserts it never occurs.
  - Pop occurs on out_valid && out_ready. out_data, out_tag and out_flags hold stable while out_valid && !out_ready.
- occupancy:
  - Incremented by an accept, decremented by a pop.
  - A simultaneous accept and pop leaves it unchanged.
- Throughput: one operation per cycle is sustained when FIFO_DEPTH >= MULT_LAT+1 and out_ready is held high.

Decomposition:
- Package fp_pkg:
  - Field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23.
  - QNAN=32'h7FC00000, EXP_ALL1=8'hFF.
  - Typedef spec_t (enum NONE, NAN, INF, ZERO).
  - Function classify(a,b) returning spec_t plus the sign.
- Sub-module fp_result_fifo: parameterised WIDTH+TAG_W+3 wide, FIFO_DEPTH deep, same clk/rst.
- The credit counter and shift register live in the top module.

Test Plan:
- Single op, behavioural multiplier model with MULT_LAT=3:
  - Stimulus: a=0x44760A04 (984.156494140625), b=0x45B7692A (5869.1455078125), tag=1.
  - Required: out_valid 4 cycles after accept; out_data=0x4AB0463B; tag=1; flags=000.
- Sign handling: a=0x40780000 (3.875), b=0xC0600000 (-3.5) → out_data=0xC1590000 (-13.5625).
- Special cases:
  - zero*inf (0x00000000, 0x7F800000) → 0x7FC00000, flags=100.
  - inf*inf (0x7F800000, 0x7F800000) → 0x7F800000, flags=010.
  - -0*2.0 (0x80000000, 0x40000000) → 0x80000000, flags=001.
- Backpressure:
  - out_ready=0, stream 8 ops.
  - Required: exactly FIFO_DEPTH=4 accepted, then in_ready=0; occupancy=4; no FIFO overflow.
  - Release out_ready: results drain in tag order 0..3; in_ready returns the cycle after the first pop.
- Full throughput: out_ready=1, 20 back-to-back ops → one accept and one pop per cycle in steady state; tags in order.
- Reset mid-flight: assert rst with 2 ops in flight → out_valid=0 immediately; no output ever appears for those tags; in_ready=1 the first cycle after rst deasserts.
